plic_responder: RTL and testbench

Memory-mapped platform-level interrupt controller target that answers the MEM stage's PLIC access port (address window 0x100000–0x3FFFFF, offset already subtracted upstream). It holds per-source priority, pending, enable, threshold and claim/complete state. It returns read data one cycle after a read strobe. It drives a single machine external interrupt line to the CSR/trap logic.

---
 rtl/plic_responder.sv | 180 ++++++++++++++++++
 tb/tb_plic_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/plic_responder.sv
// -----------------------------------------------------------------------------
// plic_responder
//   Platform-level interrupt controller target on the MEM-stage PLIC port.
//   Holds per-source priority, pending, enable and busy (gateway) state, a
//   global threshold, and the claim/complete register. It drives one
//   registered machine external interrupt line.
//
// Ports
//   clk           core clock
//   resetn        asynchronous active-low reset
//   plic_addr_i   byte offset into the PLIC window ([1:0] ignored)
//   plic_wdata_i  write data
//   plic_wen_i    write strobe (dropped when plic_ren_i is also high)
//   plic_ren_i    read strobe; data returned on plic_rdata_o next cycle
//   plic_rdata_o  registered read data, 0 in any cycle not following a read
//   irq_src_i     level-sensitive sources, bit k-1 is source ID k
//   ext_irq_o     registered "any source eligible"
//
// Build option
//   PLIC_SRC_SYNC_EN : when defined, each irq_src_i bit passes through a
//                      2-flop synchronizer before the gateway.
// -----------------------------------------------------------------------------
module plic_responder #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [23:0]        plic_addr_i,
  input  logic [31:0]        plic_wdata_i,
  input  logic               plic_wen_i,
  input  logic               plic_ren_i,
  output logic [31:0]        plic_rdata_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               ext_irq_o
);

  // Source IDs never exceed 31, so five bits always hold a winner ID.
  localparam int ID_W = 5;

  logic [PRIO_W-1:0]  prio_q [1:NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [1:NUM_SRC];
  logic [NUM_SRC:1]   enable_q, enable_d;
  logic [NUM_SRC:1]   pending_q, pending_d;
  logic [NUM_SRC:1]   busy_q, busy_d;
  logic [PRIO_W-1:0]  thr_q, thr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ext_irq_q, ext_irq_d;

  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC:1]   elig;
  logic [NUM_SRC:1]   gw_set;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic               rd, wr;
  logic               in_prio_pg, is_pend, is_en, is_thr, is_claim;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^plic_addr_i[1:0];

`ifdef PLIC_SRC_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src = sync2_q;
`else
  assign src = irq_src_i;
`endif

  // Address decode on word offsets.
  assign in_prio_pg = (plic_addr_i[23:12] == 12'h000);
  assign is_pend    = (plic_addr_i[23:2] == 22'h000400);
  assign is_en      = (plic_addr_i[23:2] == 22'h000800);
  assign is_thr     = (plic_addr_i[23:2] == 22'h080000);
  assign is_claim   = (plic_addr_i[23:2] == 22'h080001);

  // A simultaneous read wins; the write is dropped.
  assign rd = plic_ren_i;
  assign wr = plic_wen_i & ~plic_ren_i;

  // Eligibility and winner: strict '>' on priority keeps the lowest ID on ties.
  always_comb begin
    elig     = '0;
    win_id   = '0;
    win_prio = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      elig[k] = pending_q[k] & enable_q[k] & (prio_q[k] > thr_q);
      if (elig[k] && ((win_id == '0) || (prio_q[k] > win_prio))) begin
        win_id   = ID_W'(k);
        win_prio = prio_q[k];
      end
    end
  end

  // Read data mux.
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (in_prio_pg) begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          if (plic_addr_i[11:2] == 10'(k)) rdata_d = 32'(prio_q[k]);
        end
      end
      if (is_pend)  rdata_d = 32'({pending_q, 1'b0});
      if (is_en)    rdata_d = 32'({enable_q, 1'b0});
      if (is_thr)   rdata_d = 32'(thr_q);
      if (is_claim) rdata_d = 32'(win_id);
    end
  end

  // Register writes, gateway, claim and complete.
  always_comb begin
    prio_d   = prio_q;
    enable_d = enable_q;
    thr_d    = thr_q;

    // Gateway: an idle source with its input high becomes pending and busy.
    gw_set    = src & ~busy_q;
    pending_d = pending_q | gw_set;
    busy_d    = busy_q | gw_set;

    if (wr) begin
      if (in_prio_pg) begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          if (plic_addr_i[11:2] == 10'(k)) prio_d[k] = plic_wdata_i[PRIO_W-1:0];
        end
      end
      if (is_en)  enable_d = plic_wdata_i[NUM_SRC:1];
      if (is_thr) thr_d    = plic_wdata_i[PRIO_W-1:0];
      // Complete: only IDs 1..NUM_SRC release their gateway.
      if (is_claim) begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          if (plic_wdata_i == 32'(k)) busy_d[k] = 1'b0;
        end
      end
    end

    // Claim clears the winner's pending bit; busy stays set until complete.
    if (rd && is_claim) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        if (win_id == ID_W'(k)) pending_d[k] = 1'b0;
      end
    end

    ext_irq_d = |elig;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 1; k <= NUM_SRC; k++) prio_q[k] <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      busy_q    <= '0;
      thr_q     <= '0;
      rdata_q   <= '0;
      ext_irq_q <= 1'b0;
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) prio_q[k] <= prio_d[k];
      enable_q  <= enable_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      thr_q     <= thr_d;
      rdata_q   <= rdata_d;
      ext_irq_q <= ext_irq_d;
    end
  end

  assign plic_rdata_o = rdata_q;
  assign ext_irq_o    = ext_irq_q;

endmodule

// File: tb/tb_plic_responder.sv
module tb_plic_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [23:0] plic_addr_i;
  logic [31:0] plic_wdata_i;
  logic        plic_wen_i;
  logic        plic_ren_i;
  logic [31:0] plic_rdata_o;
  logic [7:0]  irq_src_i;
  logic        ext_irq_o;

  int checks = 0;
  int errors = 0;

  plic_responder #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .plic_addr_i  (plic_addr_i),
    .plic_wdata_i (plic_wdata_i),
    .plic_wen_i   (plic_wen_i),
    .plic_ren_i   (plic_ren_i),
    .plic_rdata_o (plic_rdata_o),
    .irq_src_i    (irq_src_i),
    .ext_irq_o    (ext_irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [31:0] d);
    plic_addr_i  = a;
    plic_wdata_i = d;
    plic_wen_i   = 1'b1;
    @(posedge clk);
    #1;
    plic_wen_i   = 1'b0;
  endtask

  task automatic bus_rd(input logic [23:0] a, output logic [31:0] d);
    plic_addr_i = a;
    plic_ren_i  = 1'b1;
    @(posedge clk);
    #1;
    plic_ren_i  = 1'b0;
    d = plic_rdata_o;
  endtask

  task automatic chk_rd(input string tag, input logic [23:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;

    resetn       = 1'b0;
    plic_addr_i  = '0;
    plic_wdata_i = '0;
    plic_wen_i   = 1'b0;
    plic_ren_i   = 1'b0;
    irq_src_i    = '0;
    tick(3);
    chk("reset_rdata", plic_rdata_o, 32'h0);
    chk("reset_ext_irq", 32'(ext_irq_o), 32'h0);
    resetn = 1'b1;
    tick(1);

    // Every mapped offset reads 0 after reset.
    for (int k = 0; k <= 8; k++) chk_rd($sformatf("reset_prio%0d", k), 24'(4 * k), 32'h0);
    chk_rd("reset_pending", 24'h001000, 32'h0);
    chk_rd("reset_enable", 24'h002000, 32'h0);
    chk_rd("reset_thr", 24'h200000, 32'h0);
    chk_rd("reset_claim", 24'h200004, 32'h0);
    chk("reset_ext_irq2", 32'(ext_irq_o), 32'h0);
    tick(1);
    chk("rdata_idle_zero", plic_rdata_o, 32'h0);

    // Reserved / read-only / unmapped writes have no effect.
    bus_wr(24'h000000, 32'h7);
    chk_rd("prio0_wr_ignored", 24'h000000, 32'h0);
    bus_wr(24'h001000, 32'hFF);
    chk_rd("pending_wr_ignored", 24'h001000, 32'h0);
    bus_wr(24'h000024, 32'h7);
    chk_rd("prio9_unmapped", 24'h000024, 32'h0);

    // Single source path: ID 3, priority 2, threshold 1.
    bus_wr(24'h00000C, 32'h2);
    bus_wr(24'h002000, 32'h8);
    bus_wr(24'h200000, 32'h1);
    chk_rd("prio3_rb", 24'h00000C, 32'h2);
    chk_rd("enable_rb", 24'h002000, 32'h8);
    chk_rd("thr_rb", 24'h200000, 32'h1);
    irq_src_i = 8'h04;
    tick(1);
    chk("src3_ext_t1", 32'(ext_irq_o), 32'h0);
    tick(1);
    chk("src3_ext_t2", 32'(ext_irq_o), 32'h1);
    chk_rd("src3_pending", 24'h001000, 32'h8);
    chk_rd("src3_claim", 24'h200004, 32'h3);
    chk("claim_ext_t1", 32'(ext_irq_o), 32'h1);
    tick(1);
    chk("claim_ext_t2", 32'(ext_irq_o), 32'h0);
    chk_rd("claim_pending_clr", 24'h001000, 32'h0);

    // Source 3 still high but busy: no re-pend; invalid completes ignored.
    tick(2);
    chk_rd("busy_no_repend", 24'h001000, 32'h0);
    bus_wr(24'h200004, 32'h9);
    tick(1);
    chk_rd("complete9_ignored", 24'h001000, 32'h0);
    bus_wr(24'h200004, 32'h0);
    tick(1);
    chk_rd("complete0_ignored", 24'h001000, 32'h0);
    bus_wr(24'h200004, 32'h3);
    tick(1);
    chk_rd("complete3_repend", 24'h001000, 32'h8);
    chk("repend_ext", 32'(ext_irq_o), 32'h1);
    irq_src_i = 8'h00;
    chk_rd("repend_claim", 24'h200004, 32'h3);
    bus_wr(24'h200004, 32'h3);
    tick(2);
    chk("src3_done_ext", 32'(ext_irq_o), 32'h0);

    // Priority order with ties: IDs 2(5), 5(5), 4(3).
    bus_wr(24'h000008, 32'h5);
    bus_wr(24'h000014, 32'h5);
    bus_wr(24'h000010, 32'h3);
    bus_wr(24'h002000, 32'h1FE);
    bus_wr(24'h200000, 32'h0);
    irq_src_i = 8'h1A;
    tick(2);
    chk_rd("multi_pending", 24'h001000, 32'h34);
    chk("multi_ext", 32'(ext_irq_o), 32'h1);
    chk_rd("claim_a", 24'h200004, 32'h2);
    chk_rd("claim_b", 24'h200004, 32'h5);
    chk_rd("claim_c", 24'h200004, 32'h4);
    chk_rd("claim_d", 24'h200004, 32'h0);
    irq_src_i = 8'h00;
    bus_wr(24'h200004, 32'h2);
    bus_wr(24'h200004, 32'h5);
    bus_wr(24'h200004, 32'h4);
    tick(2);
    chk_rd("multi_done_pending", 24'h001000, 32'h0);
    chk("multi_done_ext", 32'(ext_irq_o), 32'h0);

    // Priority equal to threshold is not eligible.
    bus_wr(24'h000004, 32'h2);
    bus_wr(24'h200000, 32'h2);
    irq_src_i = 8'h01;
    tick(2);
    chk_rd("thr_pending", 24'h001000, 32'h2);
    chk("thr_ext_low", 32'(ext_irq_o), 32'h0);
    chk_rd("thr_claim_none", 24'h200004, 32'h0);
    chk_rd("thr_pending_kept", 24'h001000, 32'h2);
    bus_wr(24'h200000, 32'h1);
    chk("thr_ext_t1", 32'(ext_irq_o), 32'h0);
    tick(1);
    chk("thr_ext_t2", 32'(ext_irq_o), 32'h1);

    // Simultaneous read and write: read wins, write dropped.
    plic_addr_i  = 24'h002000;
    plic_wdata_i = 32'hFF;
    plic_wen_i   = 1'b1;
    plic_ren_i   = 1'b1;
    tick(1);
    plic_wen_i   = 1'b0;
    plic_ren_i   = 1'b0;
    chk("rw_read_old", plic_rdata_o, 32'h1FE);
    chk_rd("rw_enable_kept", 24'h002000, 32'h1FE);

    // Asynchronous reset in the middle of a claim.
    plic_addr_i = 24'h200004;
    plic_ren_i  = 1'b1;
    tick(1);
    chk("midclaim_rdata", plic_rdata_o, 32'h1);
    chk("midclaim_ext", 32'(ext_irq_o), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_rdata", plic_rdata_o, 32'h0);
    chk("async_rst_ext", 32'(ext_irq_o), 32'h0);
    plic_ren_i = 1'b0;
    irq_src_i  = 8'h00;
    tick(1);
    resetn = 1'b1;
    tick(1);
    chk("post_rst_rdata", plic_rdata_o, 32'h0);
    chk_rd("post_rst_enable", 24'h002000, 32'h0);
    chk_rd("post_rst_prio1", 24'h000004, 32'h0);
    chk_rd("post_rst_thr", 24'h200000, 32'h0);
    chk_rd("post_rst_pending", 24'h001000, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
